// File: rtl/csr_file.sv
// ============================================================================
// Module   : csr_file
// Purpose  : Machine-mode CSR responder. Holds mscratch, the 64-bit cycle and
//            instret counters, and tohost. tohost writes are queued in a
//            2-entry FIFO drained over a valid/ready handshake; a full FIFO
//            stalls the pipeline.
// Options  : define CSR_COUNTERS_EN to build the cycle/instret counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_file #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic              i_rd,
  input  logic [11:0]       i_addr,
  input  logic [2:0]        i_func,
  input  logic [DWIDTH-1:0] i_data_in,
  input  logic              i_instret_inc,
  output logic [DWIDTH-1:0] o_data_out,
  output logic              o_csr_stall,
  output logic              o_tohost_valid,
  output logic [DWIDTH-1:0] o_tohost_data,
  input  logic              i_tohost_ready
);

  localparam logic [11:0] c_ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] c_ADDR_TOHOST   = 12'h51E;
  localparam logic [11:0] c_ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] c_ADDR_CYCLEH   = 12'hC80;
  localparam logic [11:0] c_ADDR_INSTRET  = 12'hC02;
  localparam logic [11:0] c_ADDR_INSTRETH = 12'hC82;

  // FIFO occupancy encoding
  localparam logic [1:0] c_ST_EMPTY = 2'd0;
  localparam logic [1:0] c_ST_ONE   = 2'd1;
  localparam logic [1:0] c_ST_FULL  = 2'd2;

  localparam int c_CW = 2 * DWIDTH;

  logic [DWIDTH-1:0] r_mscratch;
  logic [DWIDTH-1:0] r_tohost;
  logic [DWIDTH-1:0] r_fifo [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  logic [DWIDTH-1:0] w_cycle_lo;
  logic [DWIDTH-1:0] w_cycle_hi;
  logic [DWIDTH-1:0] w_instret_lo;
  logic [DWIDTH-1:0] w_instret_hi;

  logic [DWIDTH-1:0] w_old;
  logic [DWIDTH-1:0] w_new;
  logic              w_wr_ok;
  logic              w_do_write;
  logic              w_tohost_sel;
  logic              w_push;
  logic              w_pop;

`ifdef CSR_COUNTERS_EN
  logic [c_CW-1:0] r_cycle;
  logic [c_CW-1:0] r_instret;

  // Free-running cycle counter and retired-instruction counter (full-width carry).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_cycle   <= r_cycle + c_CW'(1);
      r_instret <= r_instret + c_CW'(i_instret_inc);
    end
  end

  assign w_cycle_lo   = r_cycle[DWIDTH-1:0];
  assign w_cycle_hi   = r_cycle[c_CW-1:DWIDTH];
  assign w_instret_lo = r_instret[DWIDTH-1:0];
  assign w_instret_hi = r_instret[c_CW-1:DWIDTH];
`else
  logic w_unused_instret_inc;
  assign w_unused_instret_inc = i_instret_inc;

  assign w_cycle_lo   = '0;
  assign w_cycle_hi   = '0;
  assign w_instret_lo = '0;
  assign w_instret_hi = '0;
`endif

  // Old value of the addressed CSR; unmapped addresses read as zero.
  always_comb begin
    w_old = '0;
    case (i_addr)
      c_ADDR_MSCRATCH: w_old = r_mscratch;
      c_ADDR_TOHOST:   w_old = r_tohost;
      c_ADDR_CYCLE:    w_old = w_cycle_lo;
      c_ADDR_CYCLEH:   w_old = w_cycle_hi;
      c_ADDR_INSTRET:  w_old = w_instret_lo;
      c_ADDR_INSTRETH: w_old = w_instret_hi;
      default:         w_old = '0;
    endcase
  end

  assign o_data_out = i_rd ? w_old : '0;

  // New value by funct3; set/clear with a zero operand is not a write at all.
  always_comb begin
    w_new   = w_old;
    w_wr_ok = 1'b0;
    case (i_func)
      3'b001, 3'b101: begin
        w_new   = i_data_in;
        w_wr_ok = 1'b1;
      end
      3'b010, 3'b110: begin
        w_new   = w_old | i_data_in;
        w_wr_ok = (i_data_in != '0);
      end
      3'b011, 3'b111: begin
        w_new   = w_old & ~i_data_in;
        w_wr_ok = (i_data_in != '0);
      end
      default: begin
        w_new   = w_old;
        w_wr_ok = 1'b0;
      end
    endcase
  end

  assign w_do_write   = i_we & w_wr_ok;
  assign w_tohost_sel = (i_addr == c_ADDR_TOHOST);
  // A tohost write while full is dropped; the stalled pipeline re-presents it.
  assign w_push       = w_do_write & w_tohost_sel & (r_state != c_ST_FULL);
  assign w_pop        = (r_state != c_ST_EMPTY) & i_tohost_ready;

  // Writable CSRs: mscratch, and the tohost shadow which tracks accepted pushes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mscratch <= '0;
      r_tohost   <= '0;
    end else begin
      if (w_do_write && (i_addr == c_ADDR_MSCRATCH)) begin
        r_mscratch <= w_new;
      end
      if (w_push) begin
        r_tohost <= w_new;
      end
    end
  end

  // FIFO storage and pointers; no bypass, a push always lands in an entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_new;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Occupancy next state from push/pop.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_EMPTY: begin
        if (w_push) w_state_nxt = c_ST_ONE;
      end
      c_ST_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = c_ST_FULL;
        else if (!w_push && w_pop) w_state_nxt = c_ST_EMPTY;
      end
      c_ST_FULL: begin
        if (w_pop) w_state_nxt = c_ST_ONE;
      end
      default: w_state_nxt = c_ST_EMPTY;
    endcase
  end

  // Handshake outputs and stall; stall has no dependence on the host ready.
  always_comb begin
    o_tohost_valid = (r_state != c_ST_EMPTY);
    o_tohost_data  = o_tohost_valid ? r_fifo[r_rd_ptr] : '0;
    o_csr_stall    = (r_state == c_ST_FULL) & i_we & w_tohost_sel;
  end

endmodule

`default_nettype wire

// File: tb/tb_csr_file.sv
// ============================================================================
// Module   : tb_csr_file
// Purpose  : Directed self-checking bench for csr_file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_file;

  localparam int DW = 32;
`ifdef CSR_COUNTERS_EN
  localparam bit c_CNT = 1'b1;
`else
  localparam bit c_CNT = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          we;
  logic          rd;
  logic [11:0]   addr;
  logic [2:0]    func;
  logic [DW-1:0] data_in;
  logic          instret_inc;
  logic [DW-1:0] data_out;
  logic          csr_stall;
  logic          tohost_valid;
  logic [DW-1:0] tohost_data;
  logic          tohost_ready;

  int total;
  int bad;
  int tb_cyc;

  csr_file #(.DWIDTH(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_we           (we),
    .i_rd           (rd),
    .i_addr         (addr),
    .i_func         (func),
    .i_data_in      (data_in),
    .i_instret_inc  (instret_inc),
    .o_data_out     (data_out),
    .o_csr_stall    (csr_stall),
    .o_tohost_valid (tohost_valid),
    .o_tohost_data  (tohost_data),
    .i_tohost_ready (tohost_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count: edges seen with reset released.
  always @(posedge clk) begin
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [DW-1:0] exp);
    we   = 1'b0;
    rd   = 1'b1;
    addr = a;
    #1;
    chk(tag, 64'(data_out), 64'(exp));
    rd   = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [2:0] f, input logic [DW-1:0] d);
    we      = 1'b1;
    rd      = 1'b0;
    addr    = a;
    func    = f;
    data_in = d;
    step();
    we      = 1'b0;
    data_in = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0; we = 1'b0; rd = 1'b0; addr = '0; func = '0;
    data_in = '0; instret_inc = 1'b0; tohost_ready = 1'b0;

    // Reset for three edges, then outputs are all zero
    repeat (3) @(posedge clk);
    #1;
    rd = 1'b1; addr = 12'hC00; we = 1'b1;
    #1;
    chk("rst_dout",  64'(data_out), 64'h0);
    chk("rst_valid", 64'(tohost_valid), 64'h0);
    chk("rst_tdata", 64'(tohost_data), 64'h0);
    chk("rst_stall", 64'(csr_stall), 64'h0);
    we = 1'b0; rd = 1'b0;

    // Cycle counter reads 0, 1, 2 after release
    rst_n = 1'b1;
    rd_chk("cyc0", 12'hC00, 0);
    step(); rd_chk("cyc1", 12'hC00, c_CNT ? 1 : 0);
    step(); rd_chk("cyc2", 12'hC00, c_CNT ? 2 : 0);

    // Set / clear semantics on mscratch
    wr(12'h340, 3'b001, 32'hF0F0); rd_chk("rw",   12'h340, 32'hF0F0);
    wr(12'h340, 3'b010, 32'h000F); rd_chk("rs",   12'h340, 32'hF0FF);
    wr(12'h340, 3'b011, 32'h00F0); rd_chk("rc",   12'h340, 32'hF00F);
    wr(12'h340, 3'b010, 32'h0000); rd_chk("rs0",  12'h340, 32'hF00F);
    wr(12'h340, 3'b110, 32'h0100); rd_chk("rsi",  12'h340, 32'hF10F);
    wr(12'h340, 3'b100, 32'h1234); rd_chk("badf", 12'h340, 32'hF10F);
    addr = 12'h340; rd = 1'b0; #1;
    chk("rd_off", 64'(data_out), 64'h0);
    // Read during write returns the old value
    we = 1'b1; rd = 1'b1; addr = 12'h340; func = 3'b001; data_in = 32'hAAAA; #1;
    chk("rd_old", 64'(data_out), 64'hF10F);
    step(); we = 1'b0; data_in = '0;
    rd_chk("rw2", 12'h340, 32'hAAAA);
    wr(12'h123, 3'b001, 32'h5); rd_chk("unmap", 12'h123, 0);

    // Read-only counter: write ignored
    wr(12'hC00, 3'b001, 32'h1234);
    rd_chk("ro_cyc", 12'hC00, c_CNT ? tb_cyc : 0);
    rd_chk("ro_cych", 12'hC80, 0);

    // FIFO fill, stall, drain
    tohost_ready = 1'b0;
    wr(12'h51E, 3'b001, 32'd1);
    chk("f1_valid", 64'(tohost_valid), 64'h1);
    chk("f1_data",  64'(tohost_data), 64'd1);
    wr(12'h51E, 3'b001, 32'd2);
    chk("f2_head",  64'(tohost_data), 64'd1);
    we = 1'b1; addr = 12'h51E; func = 3'b001; data_in = 32'd3; #1;
    chk("f3_stall", 64'(csr_stall), 64'h1);
    step();
    chk("f3_stall_hold", 64'(csr_stall), 64'h1);
    chk("f3_head_hold",  64'(tohost_data), 64'd1);
    rd_chk("f3_shadow", 12'h51E, 32'd2);
    we = 1'b1; addr = 12'h51E;
    tohost_ready = 1'b1; #1;
    chk("f3_stall_rdy", 64'(csr_stall), 64'h1);
    step();
    chk("d1_head",  64'(tohost_data), 64'd2);
    chk("d1_stall", 64'(csr_stall), 64'h0);
    step();
    we = 1'b0; data_in = '0;
    chk("d2_valid", 64'(tohost_valid), 64'h1);
    chk("d2_head",  64'(tohost_data), 64'd3);
    step();
    chk("d3_valid", 64'(tohost_valid), 64'h0);
    rd_chk("d3_shadow", 12'h51E, 32'd3);

    // Simultaneous push and pop in ONE
    tohost_ready = 1'b0;
    wr(12'h51E, 3'b001, 32'h11);
    tohost_ready = 1'b1;
    wr(12'h51E, 3'b001, 32'h55);
    chk("pp_valid", 64'(tohost_valid), 64'h1);
    chk("pp_head",  64'(tohost_data), 64'h55);
    step();
    chk("pp_empty", 64'(tohost_valid), 64'h0);

    // Push into EMPTY with ready high: no bypass
    wr(12'h51E, 3'b001, 32'h77);
    chk("nb_valid", 64'(tohost_valid), 64'h1);
    chk("nb_head",  64'(tohost_data), 64'h77);
    step();
    chk("nb_empty", 64'(tohost_valid), 64'h0);

    // Zero-operand set does not push; clear on tohost does
    tohost_ready = 1'b0;
    wr(12'h51E, 3'b010, 32'h0);
    chk("z_nopush", 64'(tohost_valid), 64'h0);
    wr(12'h51E, 3'b011, 32'h07);
    chk("rc_head", 64'(tohost_data), 64'h70);
    wr(12'h51E, 3'b001, 32'h99);

    // Reset mid-operation discards queue, overrides write
    rst_n = 1'b0; we = 1'b1; addr = 12'h51E; func = 3'b001; data_in = 32'hAB;
    step();
    we = 1'b0; rst_n = 1'b1;
    chk("mr_valid", 64'(tohost_valid), 64'h0);
    chk("mr_tdata", 64'(tohost_data), 64'h0);
    rd_chk("mr_shadow", 12'h51E, 0);
    rd_chk("mr_mscr",   12'h340, 0);

    // instret counting
    instret_inc = 1'b1;
    repeat (3) step();
    instret_inc = 1'b0;
    rd_chk("instret3", 12'hC02, c_CNT ? 3 : 0);
    rd_chk("instreth", 12'hC82, 0);

`ifdef CSR_COUNTERS_EN
    // Low-to-high carry on both counters
    force dut.r_instret = 64'h0000_0000_FFFF_FFFF;
    force dut.r_cycle   = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.r_instret;
    release dut.r_cycle;
    instret_inc = 1'b1;
    step();
    instret_inc = 1'b0;
    rd_chk("wrap_il", 12'hC02, 0);
    rd_chk("wrap_ih", 12'hC82, 1);
    rd_chk("wrap_cl", 12'hC00, 0);
    rd_chk("wrap_ch", 12'hC80, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
